// File: rtl/gmii_rx_pack_pkg.sv
// gmii_rx_pack_pkg
//   Shared definitions for the GMII receive packer:
//   - one-hot FSM state encodings
//   - XGMII control characters and GMII preamble/SFD bytes
//   - saturating 16-bit increment helper used by the frame counters
package gmii_rx_pack_pkg;

   typedef enum logic [7:0] {
      ST_IDLE  = 8'h01,
      ST_PREAM = 8'h02,
      ST_DATA  = 8'h04,
      ST_TERM  = 8'h08,
      ST_BCNT  = 8'h10,
      ST_DROP  = 8'h20
   } state_t;

   localparam logic [7:0] XGMII_START = 8'hFB;
   localparam logic [7:0] XGMII_TERM  = 8'hFD;
   localparam logic [7:0] XGMII_ERR   = 8'hFE;
   localparam logic [7:0] XGMII_IDLE  = 8'h07;
   localparam logic [7:0] PREAMBLE    = 8'h55;
   localparam logic [7:0] SFD         = 8'hD5;

   function automatic logic [15:0] sat_inc(input logic [15:0] v);
      return (v == 16'hffff) ? v : v + 16'd1;
   endfunction

endpackage

// File: rtl/gmii_rx_pack_if.sv
// gmii_rx_pack_if
//   Bundles the GMII receive inputs, FIFO status/strobes and the packed
//   word outputs of gmii_rx_pack.
//   slave  : the packer's view (GMII + FIFO status in, words/counts out)
//   master : the driving/observing side (GMII + FIFO status out, results in)
interface gmii_rx_pack_if;
   logic        byte_en;
   logic [7:0]  gmii_rxd;
   logic        gmii_rx_dv;
   logic        gmii_rx_er;
   logic        gige_data_fifo_afull;
   logic        gige_bcnt_fifo_full;
   logic        gige_data_fifo_we;
   logic [63:0] data_out;
   logic [7:0]  ctrl_out;
   logic        gige_bcnt_fifo_we;
   logic [15:0] bcnt_out;
   logic [15:0] frm_drop_cnt;
   logic [15:0] frm_trunc_cnt;

   modport slave (
      input  byte_en, gmii_rxd, gmii_rx_dv, gmii_rx_er,
             gige_data_fifo_afull, gige_bcnt_fifo_full,
      output gige_data_fifo_we, data_out, ctrl_out, gige_bcnt_fifo_we,
             bcnt_out, frm_drop_cnt, frm_trunc_cnt
   );

   modport master (
      output byte_en, gmii_rxd, gmii_rx_dv, gmii_rx_er,
             gige_data_fifo_afull, gige_bcnt_fifo_full,
      input  gige_data_fifo_we, data_out, ctrl_out, gige_bcnt_fifo_we,
             bcnt_out, frm_drop_cnt, frm_trunc_cnt
   );
endinterface

// File: rtl/gmii_lane_acc.sv
// gmii_lane_acc
//   8-lane byte accumulator. Bytes shift into successive lanes (lane 0 first).
//   Ports:
//     clk, reset_        clock, asynchronous active-low reset
//     clr                return the lane index to lane 0
//     shift_en, byte_in, ctrl_in   place one byte + ctrl flag in the next lane
//     word_done          this shift fills lane 7; word_data/word_ctrl hold the
//                        complete word including the incoming byte
//     flush_data/ctrl    current partial word terminated with FD in the next
//                        free lane and 07 padding above it (all ctrl=1)
module gmii_lane_acc
   import gmii_rx_pack_pkg::*;
(
   input  logic        clk,
   input  logic        reset_,
   input  logic        clr,
   input  logic        shift_en,
   input  logic [7:0]  byte_in,
   input  logic        ctrl_in,
   output logic        word_done,
   output logic [63:0] word_data,
   output logic [7:0]  word_ctrl,
   output logic [63:0] flush_data,
   output logic [7:0]  flush_ctrl
);

   logic [63:0] data_q, data_d;
   logic [7:0]  ctrl_q, ctrl_d;
   logic [2:0]  idx_q, idx_d;

   always_comb begin
      data_d = data_q;
      ctrl_d = ctrl_q;
      idx_d  = idx_q;
      if (clr) begin
         idx_d = 3'd0;
      end else if (shift_en) begin
         data_d[{idx_q, 3'b000} +: 8] = byte_in;
         ctrl_d[idx_q]                = ctrl_in;
         idx_d                        = idx_q + 3'd1;   // wraps 7 -> 0
      end
   end

   always_ff @(posedge clk or negedge reset_) begin
      if (!reset_) begin
         data_q <= '0;
         ctrl_q <= '0;
         idx_q  <= 3'd0;
      end else begin
         data_q <= data_d;
         ctrl_q <= ctrl_d;
         idx_q  <= idx_d;
      end
   end

   assign word_done = shift_en && !clr && (idx_q == 3'd7);
   assign word_data = {byte_in, data_q[55:0]};
   assign word_ctrl = {ctrl_in, ctrl_q[6:0]};

   // Lanes below the index keep their bytes, the index lane gets FD, and the
   // lanes above are padded with 07. idx=0 naturally gives {07 x7, FD}.
   generate
      for (genvar gi = 0; gi < 8; gi++) begin : g_flush
         localparam logic [2:0] LANE = 3'(gi);
         assign flush_data[gi*8 +: 8] = (LANE < idx_q)  ? data_q[gi*8 +: 8] :
                                        (LANE == idx_q) ? XGMII_TERM : XGMII_IDLE;
         assign flush_ctrl[gi]        = (LANE < idx_q)  ? ctrl_q[gi] : 1'b1;
      end
   endgenerate

endmodule

// File: rtl/gmii_rx_pack.sv
// gmii_rx_pack
//   Packs the byte-wide GMII receive stream into XGMII-style 64-bit words with
//   per-lane ctrl, writes them to the gige data FIFO and then writes the frame
//   byte count to the gige bcnt FIFO one clk after the frame's last data word.
//   Ports:
//     clk, reset_   core clock, asynchronous active-low reset
//     bus (slave)   GMII rxd/rx_dv/rx_er + byte_en, FIFO afull/full status,
//                   data/bcnt write strobes, data_out/ctrl_out/bcnt_out,
//                   saturating frm_drop_cnt / frm_trunc_cnt
module gmii_rx_pack
   import gmii_rx_pack_pkg::*;
#(
   parameter logic [15:0] MAX_BYTES = 16'd9600,
   parameter logic [63:0] IDLE_WORD = 64'h0707_0707_0707_0707
)
(
   input  logic           clk,
   input  logic           reset_,
   gmii_rx_pack_if.slave  bus
);

   localparam logic [63:0] START_WORD = {SFD, {6{PREAMBLE}}, XGMII_START};

   state_t      state_q, state_d;
   logic        data_we_q, data_we_d;
   logic [63:0] data_out_q, data_out_d;
   logic [7:0]  ctrl_out_q, ctrl_out_d;
   logic        bcnt_we_q, bcnt_we_d;
   logic [15:0] bcnt_out_q, bcnt_out_d;
   logic [15:0] bcnt_q, bcnt_d;
   logic [15:0] drop_cnt_q, drop_cnt_d;
   logic [15:0] trunc_cnt_q, trunc_cnt_d;
   logic        trunc_q, trunc_d;     // current frame was truncated
   logic        late_q, late_d;       // new frame started during TERM

   logic        acc_clr, acc_shift, acc_ctrl, word_done;
   logic [7:0]  acc_byte, word_ctrl, flush_ctrl;
   logic [63:0] word_data, flush_data;
   logic        dv_byte;

   assign dv_byte = bus.byte_en && bus.gmii_rx_dv;

   gmii_lane_acc u_lane_acc (
      .clk        (clk),
      .reset_     (reset_),
      .clr        (acc_clr),
      .shift_en   (acc_shift),
      .byte_in    (acc_byte),
      .ctrl_in    (acc_ctrl),
      .word_done  (word_done),
      .word_data  (word_data),
      .word_ctrl  (word_ctrl),
      .flush_data (flush_data),
      .flush_ctrl (flush_ctrl)
   );

   always_comb begin
      state_d     = state_q;
      data_we_d   = 1'b0;
      data_out_d  = data_out_q;
      ctrl_out_d  = ctrl_out_q;
      bcnt_we_d   = 1'b0;
      bcnt_out_d  = bcnt_out_q;
      bcnt_d      = bcnt_q;
      drop_cnt_d  = drop_cnt_q;
      trunc_cnt_d = trunc_cnt_q;
      trunc_d     = trunc_q;
      late_d      = late_q;
      acc_clr     = 1'b0;
      acc_shift   = 1'b0;
      acc_byte    = bus.gmii_rx_er ? XGMII_ERR : bus.gmii_rxd;
      acc_ctrl    = bus.gmii_rx_er;

      unique case (state_q)
         ST_IDLE: begin
            trunc_d = 1'b0;
            late_d  = 1'b0;
            if (dv_byte) state_d = ST_PREAM;
         end
         ST_PREAM: begin
            if (bus.byte_en) begin
               if (!bus.gmii_rx_dv) begin
                  state_d = ST_IDLE;
               end else if (bus.gmii_rxd == SFD) begin
                  // Space is only checked here; the afull margin covers a
                  // maximum-length frame, so later afull changes are ignored.
                  if (bus.gmii_rx_er || bus.gige_data_fifo_afull ||
                      bus.gige_bcnt_fifo_full) begin
                     drop_cnt_d = sat_inc(drop_cnt_q);
                     state_d    = ST_DROP;
                  end else begin
                     data_we_d  = 1'b1;
                     data_out_d = START_WORD;
                     ctrl_out_d = 8'h01;
                     bcnt_d     = 16'd8;
                     acc_clr    = 1'b1;
                     state_d    = ST_DATA;
                  end
               end
            end
         end
         ST_DATA: begin
            if (bus.byte_en) begin
               if (!bus.gmii_rx_dv) begin
                  state_d = ST_TERM;
               end else begin
                  acc_shift = 1'b1;
                  bcnt_d    = bcnt_q + 16'd1;
                  if (word_done) begin
                     data_we_d  = 1'b1;
                     data_out_d = word_data;
                     ctrl_out_d = word_ctrl;
                  end
                  // Leave room for the FD so bcnt tops out at MAX_BYTES.
                  if (bcnt_q + 16'd1 == MAX_BYTES - 16'd1) begin
                     trunc_d     = 1'b1;
                     trunc_cnt_d = sat_inc(trunc_cnt_q);
                     state_d     = ST_TERM;
                  end
               end
            end
         end
         ST_TERM: begin
            data_we_d  = 1'b1;
            data_out_d = flush_data;
            ctrl_out_d = flush_ctrl;
            bcnt_d     = bcnt_q + 16'd1;
            acc_clr    = 1'b1;
            if (dv_byte) late_d = 1'b1;
            state_d    = ST_BCNT;
         end
         ST_BCNT: begin
            bcnt_we_d  = 1'b1;
            bcnt_out_d = bcnt_q;
            trunc_d    = 1'b0;
            late_d     = 1'b0;
            if (trunc_q) begin
               // Remainder of a truncated frame is still on the wire.
               state_d = ST_DROP;
            end else if (late_q || dv_byte) begin
               drop_cnt_d = sat_inc(drop_cnt_q);
               state_d    = ST_DROP;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_DROP: begin
            if (bus.byte_en && !bus.gmii_rx_dv) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset_) begin
      if (!reset_) begin
         state_q     <= ST_IDLE;
         data_we_q   <= 1'b0;
         data_out_q  <= IDLE_WORD;
         ctrl_out_q  <= 8'hff;
         bcnt_we_q   <= 1'b0;
         bcnt_out_q  <= '0;
         bcnt_q      <= '0;
         drop_cnt_q  <= '0;
         trunc_cnt_q <= '0;
         trunc_q     <= 1'b0;
         late_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         data_we_q   <= data_we_d;
         data_out_q  <= data_out_d;
         ctrl_out_q  <= ctrl_out_d;
         bcnt_we_q   <= bcnt_we_d;
         bcnt_out_q  <= bcnt_out_d;
         bcnt_q      <= bcnt_d;
         drop_cnt_q  <= drop_cnt_d;
         trunc_cnt_q <= trunc_cnt_d;
         trunc_q     <= trunc_d;
         late_q      <= late_d;
      end
   end

   assign bus.gige_data_fifo_we = data_we_q;
   assign bus.data_out          = data_out_q;
   assign bus.ctrl_out          = ctrl_out_q;
   assign bus.gige_bcnt_fifo_we = bcnt_we_q;
   assign bus.bcnt_out          = bcnt_out_q;
   assign bus.frm_drop_cnt      = drop_cnt_q;
   assign bus.frm_trunc_cnt     = trunc_cnt_q;

endmodule

// File: tb/tb_gmii_rx_pack.sv
// tb_gmii_rx_pack
//   Directed frames into gmii_rx_pack. A frame-level model builds the expected
//   on-wire byte list (start, payload/FE, FD, 07 pad), slices it into 64-bit
//   words and a byte count; a negedge monitor checks every FIFO write against
//   it. Literal expectations pin key words, counts and reset values.
module tb_gmii_rx_pack;

   localparam int MAXB = 9600;

   typedef struct packed {
      logic [63:0] d;
      logic [7:0]  c;
   } word_t;

   logic clk = 1'b0;
   logic reset_ = 1'b0;
   always #5 clk = ~clk;

   gmii_rx_pack_if bus();

   gmii_rx_pack #(
      .MAX_BYTES (16'd9600),
      .IDLE_WORD (64'h0707_0707_0707_0707)
   ) dut (
      .clk    (clk),
      .reset_ (reset_),
      .bus    (bus)
   );

   int    vectors = 0;
   int    miscompares = 0;
   word_t exp_w[$];
   int    exp_b[$];
   word_t cap_w[$];
   word_t f1_w[$];
   word_t e_w;
   int    e_b;
   int    last_bcnt = -1;
   int    n_data_wr = 0;
   int    n_bcnt_wr = 0;
   logic  prev_we = 1'b0;
   int    gap_g = 0;
   int    wr_before;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Monitor: every data/bcnt write is checked against the model queues.
   always @(negedge clk) begin
      if (reset_) begin
         if (bus.gige_data_fifo_we) begin
            n_data_wr++;
            cap_w.push_back({bus.data_out, bus.ctrl_out});
            if (exp_w.size() == 0) begin
               chk("unexpected_data_we", 64'd1, 64'd0);
            end else begin
               e_w = exp_w.pop_front();
               chk("data_out", bus.data_out, e_w.d);
               chk("ctrl_out", 64'(bus.ctrl_out), 64'(e_w.c));
            end
         end
         if (bus.gige_bcnt_fifo_we) begin
            n_bcnt_wr++;
            last_bcnt = int'(bus.bcnt_out);
            chk("bcnt_after_last_data", 64'(prev_we), 64'd1);
            if (exp_b.size() == 0) begin
               chk("unexpected_bcnt_we", 64'd1, 64'd0);
            end else begin
               e_b = exp_b.pop_front();
               chk("bcnt_out", 64'(bus.bcnt_out), 64'(e_b));
            end
         end
         prev_we = bus.gige_data_fifo_we;
      end else begin
         prev_we = 1'b0;
      end
   end

   // Frame model: bytes as they appear on the XGMII side, then word slicing.
   task automatic model_frame(input int n, input int err_pos, input int stop_at);
      logic [7:0] b[$];
      logic       c[$];
      word_t      w;
      b.push_back(8'hFB); c.push_back(1'b1);
      repeat (6) begin b.push_back(8'h55); c.push_back(1'b0); end
      b.push_back(8'hD5); c.push_back(1'b0);
      for (int i = 0; i < n; i++) begin
         if (stop_at >= 0 && i >= stop_at) break;
         if (b.size() == MAXB - 1) break;
         if (i == err_pos) begin b.push_back(8'hFE); c.push_back(1'b1); end
         else begin b.push_back(i[7:0]); c.push_back(1'b0); end
      end
      if (stop_at < 0) begin
         b.push_back(8'hFD); c.push_back(1'b1);
         exp_b.push_back(b.size());
         while (b.size() % 8 != 0) begin b.push_back(8'h07); c.push_back(1'b1); end
      end
      for (int wi = 0; wi < b.size() / 8; wi++) begin
         for (int k = 0; k < 8; k++) begin
            w.d[k*8 +: 8] = b[wi*8 + k];
            w.c[k]        = c[wi*8 + k];
         end
         exp_w.push_back(w);
      end
   endtask

   task automatic put_byte(input logic [7:0] b, input logic dv, input logic er);
      repeat (gap_g) begin
         bus.byte_en = 1'b0;
         @(posedge clk); #1;
      end
      bus.byte_en    = 1'b1;
      bus.gmii_rxd   = b;
      bus.gmii_rx_dv = dv;
      bus.gmii_rx_er = er;
      @(posedge clk); #1;
      bus.byte_en    = 1'b0;
      bus.gmii_rx_er = 1'b0;
   endtask

   task automatic run_frame(input string name, input int n, input int err_pos,
                            input int stop_at, input logic afull, input int gap);
      cap_w.delete();
      gap_g = gap;
      if (!afull) model_frame(n, err_pos, stop_at);
      bus.gige_data_fifo_afull = afull;
      repeat (7) put_byte(8'h55, 1'b1, 1'b0);
      put_byte(8'hD5, 1'b1, 1'b0);
      bus.gige_data_fifo_afull = 1'b0;
      for (int i = 0; i < n; i++) begin
         if (stop_at >= 0 && i == stop_at) begin
            $display("frame %s: stopped after %0d payload bytes, words=%0d", name, i, cap_w.size());
            return;
         end
         put_byte(i[7:0], 1'b1, (i == err_pos));
      end
      gap_g = 0;
      repeat (12) put_byte(8'h00, 1'b0, 1'b0);
      chk("drain_data_queue", 64'(exp_w.size()), 64'd0);
      chk("drain_bcnt_queue", 64'(exp_b.size()), 64'd0);
      $display("frame %s: payload=%0d words=%0d bcnt=%0d drop=%0d trunc=%0d",
               name, n, cap_w.size(), last_bcnt, bus.frm_drop_cnt, bus.frm_trunc_cnt);
   endtask

   task automatic chk_reset_state(input string tag);
      chk({tag, "_data_out"}, bus.data_out, 64'h0707_0707_0707_0707);
      chk({tag, "_ctrl_out"}, 64'(bus.ctrl_out), 64'hff);
      chk({tag, "_data_we"}, 64'(bus.gige_data_fifo_we), 64'd0);
      chk({tag, "_bcnt_we"}, 64'(bus.gige_bcnt_fifo_we), 64'd0);
      chk({tag, "_bcnt_out"}, 64'(bus.bcnt_out), 64'd0);
      chk({tag, "_drop_cnt"}, 64'(bus.frm_drop_cnt), 64'd0);
      chk({tag, "_trunc_cnt"}, 64'(bus.frm_trunc_cnt), 64'd0);
   endtask

   initial begin
      bus.byte_en = 1'b0;
      bus.gmii_rxd = 8'h00;
      bus.gmii_rx_dv = 1'b0;
      bus.gmii_rx_er = 1'b0;
      bus.gige_data_fifo_afull = 1'b0;
      bus.gige_bcnt_fifo_full = 1'b0;

      repeat (3) @(posedge clk);
      #1;
      chk_reset_state("por");
      @(negedge clk);
      reset_ = 1'b1;
      @(posedge clk); #1;
      repeat (4) put_byte(8'h00, 1'b0, 1'b0);

      // 60-byte payload
      run_frame("f60", 60, -1, -1, 1'b0, 0);
      chk("f60_nwords", 64'(cap_w.size()), 64'd9);
      chk("f60_start", cap_w[0].d, 64'hD555_5555_5555_55FB);
      chk("f60_start_ctrl", 64'(cap_w[0].c), 64'h01);
      chk("f60_last", cap_w[8].d, 64'h0707_07FD_3B3A_3938);
      chk("f60_last_ctrl", 64'(cap_w[8].c), 64'hf0);
      chk("f60_bcnt", 64'(last_bcnt), 64'd69);
      f1_w = cap_w;

      // 56-byte payload: last data word exact, TERM word is all control
      run_frame("f56", 56, -1, -1, 1'b0, 0);
      chk("f56_nwords", 64'(cap_w.size()), 64'd9);
      chk("f56_last", cap_w[8].d, 64'h0707_0707_0707_07FD);
      chk("f56_last_ctrl", 64'(cap_w[8].c), 64'hff);
      chk("f56_bcnt", 64'(last_bcnt), 64'd65);

      // afull at SFD: dropped, nothing written
      wr_before = n_data_wr + n_bcnt_wr;
      run_frame("afull", 60, -1, -1, 1'b1, 0);
      chk("afull_no_writes", 64'(n_data_wr + n_bcnt_wr), 64'(wr_before));
      chk("afull_drop_cnt", 64'(bus.frm_drop_cnt), 64'd1);
      run_frame("after_afull", 60, -1, -1, 1'b0, 0);
      chk("after_afull_bcnt", 64'(last_bcnt), 64'd69);

      // rx_er on 10th payload byte
      run_frame("rx_er", 60, 9, -1, 1'b0, 0);
      chk("rx_er_lane", 64'(cap_w[2].d[15:8]), 64'hFE);
      chk("rx_er_ctrl", 64'(cap_w[2].c), 64'h02);
      chk("rx_er_bcnt", 64'(last_bcnt), 64'd69);

      // oversize frame truncated at MAX_BYTES
      run_frame("trunc", 9700, -1, -1, 1'b0, 0);
      chk("trunc_nwords", 64'(cap_w.size()), 64'd1200);
      chk("trunc_last", cap_w[1199].d, 64'hFD76_7574_7372_7170);
      chk("trunc_last_ctrl", 64'(cap_w[1199].c), 64'h80);
      chk("trunc_bcnt", 64'(last_bcnt), 64'd9600);
      chk("trunc_cnt", 64'(bus.frm_trunc_cnt), 64'd1);
      chk("trunc_no_drop", 64'(bus.frm_drop_cnt), 64'd1);
      run_frame("after_trunc", 56, -1, -1, 1'b0, 0);
      chk("after_trunc_bcnt", 64'(last_bcnt), 64'd65);

      // reset mid-DATA
      run_frame("reset_mid", 60, -1, 20, 1'b0, 0);
      @(negedge clk);
      #2;
      reset_ = 1'b0;
      #1;
      chk_reset_state("mid_reset");
      chk("mid_reset_queue", 64'(exp_w.size()), 64'd0);
      bus.gmii_rx_dv = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      reset_ = 1'b1;
      @(posedge clk); #1;
      repeat (4) put_byte(8'h00, 1'b0, 1'b0);

      // byte_en gaps of 3 clks: same word contents as the first frame
      run_frame("gap3", 60, -1, -1, 1'b0, 3);
      chk("gap3_nwords", 64'(cap_w.size()), 64'd9);
      for (int i = 0; i < 9; i++) begin
         chk("gap3_word", cap_w[i].d, f1_w[i].d);
         chk("gap3_ctrl", 64'(cap_w[i].c), 64'(f1_w[i].c));
      end
      chk("gap3_bcnt", 64'(last_bcnt), 64'd69);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   // Global time limit so the run can never hang.
   initial begin
      #2_000_000;
      $display("FAIL timeout: got no finish expected finish before limit");
      $fatal(1, "timeout");
   end

endmodule
